// File: rtl/rvv_pkg.sv
// RVV shared types and constants for the vector configuration path.
// Provides the instruction encodings for vsetvli/vsetvl, the vtype CSR layout,
// the LMUL encoding and a helper that checks a vtype value for legality.
package rvv_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [6:0] OPCODE_VEC        = 7'b1010111;
    localparam logic [6:0] VCFG_VSETVL_FUNC7 = 7'b1000000;

    typedef enum logic [2:0] {
        OPIVV = 3'b000,
        OPFVV = 3'b001,
        OPMVV = 3'b010,
        OPIVI = 3'b011,
        OPIVX = 3'b100,
        OPFVF = 3'b101,
        OPMVX = 3'b110,
        OPCFG = 3'b111
    } opcodev_func3_e;

    typedef enum logic [2:0] {
        EW8, EW16, EW32, EW64, EW128, EW256, EW512, EW1024
    } vew_e;

    // {vlmul2, vlmul[1:0]}; the fractional encodings wrap around from 111 downwards.
    typedef enum logic [2:0] {
        LMUL_1    = 3'b000,
        LMUL_2    = 3'b001,
        LMUL_4    = 3'b010,
        LMUL_8    = 3'b011,
        LMUL_RSVD = 3'b100,
        LMUL_1_8  = 3'b101,
        LMUL_1_4  = 3'b110,
        LMUL_1_2  = 3'b111
    } lmul_e;

    // vlmul2 sits above vsew, so e32/m1 encodes as 0x008.
    typedef struct packed {
        logic            vill;
        logic [XLEN-10:0] wpri;
        logic            vma;
        logic            vta;
        logic            vlmul2;
        vew_e            vsew;
        logic [1:0]      vlmul;
    } vtype_t;

    localparam vtype_t VTYPE_ILLEGAL = vtype_t'({1'b1, {(XLEN-1){1'b0}}});

    typedef struct packed {
        logic           func1;
        logic [10:0]    zimm11;
        logic [4:0]     rs1;
        opcodev_func3_e func3;
        logic [4:0]     rd;
        logic [6:0]     opcode;
    } vsetvli_type_t;

    typedef struct packed {
        logic [6:0]     func7;
        logic [4:0]     rs2;
        logic [4:0]     rs1;
        opcodev_func3_e func3;
        logic [4:0]     rd;
        logic [6:0]     opcode;
    } vsetvl_type_t;

    typedef union packed {
        logic [31:0]   instr;
        vsetvli_type_t vsetvli_type;
        vsetvl_type_t  vsetvl_type;
    } rvv_instruction_t;

    function automatic lmul_e vtype_lmul(vtype_t vt);
        return lmul_e'({vt.vlmul2, vt.vlmul});
    endfunction

    function automatic logic vtype_is_legal(vtype_t vt);
        return !vt.vill && (vt.wpri == '0) && (vt.vsew <= EW64) &&
               (vtype_lmul(vt) != LMUL_RSVD);
    endfunction

endpackage

// File: rtl/rvv_vlmax_calc.sv
// VLMAX calculator: VLEN / SEW scaled by LMUL, purely combinational.
// Ports:
//   vsew_i  - selected element width
//   lmul_i  - selected LMUL encoding
//   vlmax_o - maximum vector length in elements (0 for reserved LMUL or tiny fractions)
module rvv_vlmax_calc
    import rvv_pkg::*;
#(
    parameter int unsigned VLEN = 4096
) (
    input  vew_e                 vsew_i,
    input  lmul_e                lmul_i,
    output logic [$clog2(VLEN):0] vlmax_o
);

    localparam int unsigned VlmaxW = $clog2(VLEN) + 1;
    localparam logic [VlmaxW-1:0] VlenW = VlmaxW'(VLEN);

    // Element count for LMUL=1: VLEN >> (3 + vsew).
    logic [VlmaxW-1:0] elems_m1;

    always_comb begin
        elems_m1 = VlenW >> ({1'b0, vsew_i} + 4'd3);
        case (lmul_i)
            LMUL_1:    vlmax_o = elems_m1;
            LMUL_2:    vlmax_o = elems_m1 << 1;
            LMUL_4:    vlmax_o = elems_m1 << 2;
            LMUL_8:    vlmax_o = elems_m1 << 3;
            LMUL_1_2:  vlmax_o = elems_m1 >> 1;
            LMUL_1_4:  vlmax_o = elems_m1 >> 2;
            LMUL_1_8:  vlmax_o = elems_m1 >> 3;
            default:   vlmax_o = '0;
        endcase
    end

endmodule

// File: rtl/rvv_vcfg_unit.sv
// RVV configuration unit: executes vsetvli/vsetvl and owns the vl and vtype CSRs.
// Ports:
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   req_*                 - request from the accelerator interface (insn, rs1=AVL, rs2=vtype)
//   resp_*                - response with the new vl as rd value and an illegal flag
//   vl_o, vtype_o         - architectural CSRs consumed by the dispatcher
// Flow: IDLE captures a request, CALC decodes and computes vl (CSRs written on leaving
// CALC), RESP holds the response until it is accepted.
module rvv_vcfg_unit #(
    parameter int unsigned VLEN = 4096,
    parameter int unsigned XLEN = rvv_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [31:0]     req_insn_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [XLEN-1:0] req_rs2_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_rd_o,
    output logic            resp_illegal_o,
    output logic [XLEN-1:0] vl_o,
    output logic [XLEN-1:0] vtype_o
);

    import rvv_pkg::*;

    localparam int unsigned VlmaxW = $clog2(VLEN) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     insn_q, insn_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] vl_q, vl_d;
    vtype_t          vtype_q, vtype_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic            illegal_q, illegal_d;

    rvv_instruction_t insn;
    logic             is_opcfg;
    logic             is_vsetvli;
    logic             is_vsetvl;
    logic             cfg_legal;
    vtype_t           src_vtype;
    lmul_e            src_lmul;
    logic             src_legal;
    logic [VlmaxW-1:0] vlmax;
    logic [XLEN-1:0]  vlmax_x;
    logic [XLEN-1:0]  avl;
    logic [XLEN-1:0]  new_vl;
    vtype_t           new_vtype;

    // Decode of the captured instruction and selection of the requested vtype.
    always_comb begin : decode
        insn       = rvv_instruction_t'(insn_q);
        is_opcfg   = (insn.vsetvli_type.opcode == OPCODE_VEC) &&
                     (insn.vsetvli_type.func3 == OPCFG);
        is_vsetvli = is_opcfg && !insn.vsetvli_type.func1;
        is_vsetvl  = is_opcfg && insn.vsetvli_type.func1 &&
                     (insn.vsetvl_type.func7 == VCFG_VSETVL_FUNC7);
        cfg_legal  = is_vsetvli || is_vsetvl;
        src_vtype  = is_vsetvl ? vtype_t'(rs2_q)
                               : vtype_t'(XLEN'(insn.vsetvli_type.zimm11));
        src_lmul   = vtype_lmul(src_vtype);
        src_legal  = vtype_is_legal(src_vtype);
    end

    rvv_vlmax_calc #(
        .VLEN(VLEN)
    ) i_vlmax_calc (
        .vsew_i (src_vtype.vsew),
        .lmul_i (src_lmul),
        .vlmax_o(vlmax)
    );

    // AVL selection and vl = min(AVL, VLMAX); an illegal vtype forces vl to zero.
    always_comb begin : vl_compute
        vlmax_x = XLEN'(vlmax);
        if (insn.vsetvli_type.rs1 != 5'd0) begin
            avl = rs1_q;
        end else if (insn.vsetvli_type.rd != 5'd0) begin
            avl = vlmax_x;
        end else begin
            avl = vl_q;
        end
        if (src_legal) begin
            new_vl    = (avl < vlmax_x) ? avl : vlmax_x;
            new_vtype = src_vtype;
        end else begin
            new_vl    = '0;
            new_vtype = VTYPE_ILLEGAL;
        end
    end

    always_comb begin : fsm
        state_d      = state_q;
        insn_d       = insn_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        vl_d         = vl_q;
        vtype_d      = vtype_q;
        rd_d         = rd_q;
        illegal_d    = illegal_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    insn_d  = req_insn_i;
                    rs1_d   = req_rs1_i;
                    rs2_d   = req_rs2_i;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                state_d = StResp;
                if (cfg_legal) begin
                    vl_d      = new_vl;
                    vtype_d   = new_vtype;
                    rd_d      = new_vl;
                    illegal_d = 1'b0;
                end else begin
                    rd_d      = '0;
                    illegal_d = 1'b1;
                end
            end
            StResp: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            insn_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            vl_q      <= '0;
            vtype_q   <= VTYPE_ILLEGAL;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            insn_q    <= insn_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            vl_q      <= vl_d;
            vtype_q   <= vtype_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end
    end

    assign resp_rd_o      = rd_q;
    assign resp_illegal_o = illegal_q;
    assign vl_o           = vl_q;
    assign vtype_o        = XLEN'(vtype_q);

endmodule
